// File: rtl/s2c_pkg.sv
// s2c protocol constants and responder FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s2c_pkg;

   localparam int          S2C_DATA_SIZE   = 16;
   localparam logic [31:0] S2C_FN_END      = 32'h0000_00FF;
   localparam logic [31:0] S2C_RET_OK      = 32'h0000_0000;
   localparam logic [31:0] S2C_RET_TIMEOUT = 32'hFFFF_FFFF;

   typedef enum logic [3:0] {
      IDLE,
      RX_FN,
      RX_DATA,
      CALL,
      WAIT,
      TX_ID,
      TX_FN,
      TX_RET,
      TX_DATA
   } s2c_resp_state_e;

endpackage

// File: rtl/s2c_responder_if.sv
// Bundles the request stream, response stream, user call/done handshake and status.
// Latency: n/a (wiring only).
// Backpressure: req/rsp/call are valid/ready; done is always accepted.
// Ports: req_* (host->responder), rsp_* (responder->host), call_*/done_* (user logic), busy/end_flag.
interface s2c_responder_if
   import s2c_pkg::*;
#(
   parameter int DATA_SIZE = S2C_DATA_SIZE
);
   logic                      req_valid;
   logic                      req_ready;
   logic [31:0]               req_data;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [31:0]               rsp_data;
   logic                      rsp_last;

   logic                      call_valid;
   logic                      call_ready;
   logic [31:0]               call_id;
   logic [31:0]               call_fn;
   logic [32*DATA_SIZE-1:0]   call_data;

   logic                      done_valid;
   logic [31:0]               done_ret;
   logic [32*DATA_SIZE-1:0]   done_data;

   logic                      busy;
   logic                      end_flag;

   // Responder side
   modport slave (
      input  req_valid, req_data, rsp_ready, call_ready, done_valid, done_ret, done_data,
      output req_ready, rsp_valid, rsp_data, rsp_last, call_valid, call_id, call_fn, call_data,
             busy, end_flag
   );

   // Host transport plus user handler side
   modport master (
      output req_valid, req_data, rsp_ready, call_ready, done_valid, done_ret, done_data,
      input  req_ready, rsp_valid, rsp_data, rsp_last, call_valid, call_id, call_fn, call_data,
             busy, end_flag
   );
endinterface

// File: rtl/s2c_rsp_ser.sv
// Serializes a latched response (id, fn, ret, DATA_SIZE data words) onto a 32-bit stream.
// Latency: first word valid the cycle after i_start; one word per cycle when ready.
// Backpressure: holds o_rsp_data stable and does not advance while i_rsp_ready is low.
// Ports: i_start kicks a packet; i_id/i_fn/i_ret/i_data must stay stable until o_done;
//        o_rsp_valid/o_rsp_data/o_rsp_last drive the stream; o_done pulses on last-word accept.
module s2c_rsp_ser
   import s2c_pkg::*;
#(
   parameter int DATA_SIZE = S2C_DATA_SIZE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic [31:0]                i_id,
   input  logic [31:0]                i_fn,
   input  logic [31:0]                i_ret,
   input  logic [DATA_SIZE-1:0][31:0] i_data,
   input  logic                       i_rsp_ready,
   output logic                       o_rsp_valid,
   output logic [31:0]                o_rsp_data,
   output logic                       o_rsp_last,
   output logic                       o_done
);
   localparam int              NWORDS = DATA_SIZE + 3;
   localparam int              IW     = $clog2(NWORDS);
   localparam logic [IW-1:0]   LAST_W = IW'(NWORDS - 1);

   logic          r_active;
   logic [IW-1:0] r_idx;
   logic          w_fire;
   logic          w_last;

   assign w_fire = r_active && i_rsp_ready;
   assign w_last = (r_idx == LAST_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= 1'b0;
         r_idx    <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_idx    <= '0;
      end else if (w_fire) begin
         if (w_last) begin
            r_active <= 1'b0;
            r_idx    <= '0;
         end else begin
            r_idx    <= r_idx + IW'(1);
         end
      end
   end

   // Word order: id, fn, ret, then data[0..DATA_SIZE-1]; zero when idle.
   always_comb begin
      o_rsp_data = '0;
      if (r_active) begin
         if (r_idx == IW'(0)) begin
            o_rsp_data = i_id;
         end else if (r_idx == IW'(1)) begin
            o_rsp_data = i_fn;
         end else if (r_idx == IW'(2)) begin
            o_rsp_data = i_ret;
         end else begin
            for (int i = 0; i < DATA_SIZE; i++) begin
               if (int'(r_idx) == i + 3) o_rsp_data = i_data[i];
            end
         end
      end
   end

   assign o_rsp_valid = r_active;
   assign o_rsp_last  = r_active && w_last;
   assign o_done      = w_fire && w_last;

endmodule

// File: rtl/s2c_responder.sv
// s2c function-call responder: deserialize request, call user logic, serialize response.
// Latency: call_valid the cycle after the last request word; response starts the cycle after done.
// Backpressure: one packet in flight; req_ready low from CALL until the last response word is taken.
// Ports: clk, rst (sync, active-high), bus (s2c_responder_if.slave: req/rsp streams, call/done, busy, end_flag).
// Optional: define S2C_RESP_TIMEOUT_EN to return S2C_RET_TIMEOUT after TIMEOUT_CYC WAIT cycles.
module s2c_responder
   import s2c_pkg::*;
#(
   parameter int DATA_SIZE   = S2C_DATA_SIZE,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic           clk,
   input  logic           rst,
   s2c_responder_if.slave bus
);
   localparam int            CW       = $clog2(DATA_SIZE + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(DATA_SIZE - 1);

   if (DATA_SIZE < 1) begin : g_bad_data_size
      $error("s2c_responder: DATA_SIZE must be >= 1");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("s2c_responder: TIMEOUT_CYC must be >= 1");
   end

   s2c_resp_state_e            r_state;
   s2c_resp_state_e            w_state_nxt;
   logic [CW-1:0]              r_cnt;
   logic [31:0]                r_id;
   logic [31:0]                r_fn;
   logic [31:0]                r_ret;
   logic [DATA_SIZE-1:0][31:0] r_data;
   logic                       r_end;

   logic                       w_req_rdy;
   logic                       w_req_fire;
   logic                       w_rx_last;
   logic                       w_tx_start;
   logic                       w_tmo;
   logic                       w_rsp_vld;
   logic                       w_rsp_fire;
   logic                       w_ser_done;

   assign w_req_rdy  = (r_state == IDLE) || (r_state == RX_FN) || (r_state == RX_DATA);
   assign w_req_fire = bus.req_valid && w_req_rdy;
   assign w_rx_last  = w_req_fire && (r_state == RX_DATA) && (r_cnt == LAST_IDX);
   assign w_rsp_fire = w_rsp_vld && bus.rsp_ready;
   // Serializer is kicked on the cycle we decide to enter TX_ID, so its first word lines up with TX_ID.
   assign w_tx_start = (w_state_nxt == TX_ID) && (r_state != TX_ID);

`ifdef S2C_RESP_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] r_tmo_cnt;

   // Zero outside WAIT, so every entry into WAIT starts counting from zero.
   always_ff @(posedge clk) begin
      if (rst || (r_state != WAIT)) r_tmo_cnt <= '0;
      else                          r_tmo_cnt <= r_tmo_cnt + TW'(1);
   end

   assign w_tmo = (r_state == WAIT) && (r_tmo_cnt == TMO_LAST);
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req_fire)     w_state_nxt = RX_FN;
         RX_FN:   if (w_req_fire)     w_state_nxt = RX_DATA;
         RX_DATA: if (w_rx_last)      w_state_nxt = (r_fn == S2C_FN_END) ? TX_ID : CALL;
         CALL:    if (bus.call_ready) w_state_nxt = WAIT;
         WAIT:    if (bus.done_valid || w_tmo) w_state_nxt = TX_ID;
         TX_ID:   if (w_rsp_fire)     w_state_nxt = TX_FN;
         TX_FN:   if (w_rsp_fire)     w_state_nxt = TX_RET;
         TX_RET:  if (w_rsp_fire)     w_state_nxt = TX_DATA;
         TX_DATA: if (w_ser_done)     w_state_nxt = IDLE;
         default:                     w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_id   <= '0;
         r_fn   <= '0;
         r_ret  <= '0;
         r_data <= '0;
         r_end  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_fire) r_id <= bus.req_data;
            end
            RX_FN: begin
               if (w_req_fire) begin
                  r_fn  <= bus.req_data;
                  r_cnt <= '0;
               end
            end
            RX_DATA: begin
               if (w_req_fire) begin
                  for (int i = 0; i < DATA_SIZE; i++) begin
                     if (int'(r_cnt) == i) r_data[i] <= bus.req_data;
                  end
                  if (r_cnt == LAST_IDX) begin
                     r_cnt <= '0;
                     // End packet: echo data back with RET_OK and skip the user call.
                     if (r_fn == S2C_FN_END) begin
                        r_end <= 1'b1;
                        r_ret <= S2C_RET_OK;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            WAIT: begin
               // A done arriving on the timeout cycle still wins.
               if (bus.done_valid) begin
                  r_ret  <= bus.done_ret;
                  r_data <= bus.done_data;
               end else if (w_tmo) begin
                  r_ret  <= S2C_RET_TIMEOUT;
                  r_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   s2c_rsp_ser #(
      .DATA_SIZE (DATA_SIZE)
   ) u_rsp_ser (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_tx_start),
      .i_id        (r_id),
      .i_fn        (r_fn),
      .i_ret       (r_ret),
      .i_data      (r_data),
      .i_rsp_ready (bus.rsp_ready),
      .o_rsp_valid (w_rsp_vld),
      .o_rsp_data  (bus.rsp_data),
      .o_rsp_last  (bus.rsp_last),
      .o_done      (w_ser_done)
   );

   assign bus.rsp_valid  = w_rsp_vld;
   assign bus.req_ready  = w_req_rdy;
   assign bus.call_valid = (r_state == CALL);
   assign bus.call_id    = r_id;
   assign bus.call_fn    = r_fn;
   assign bus.call_data  = r_data;
   assign bus.busy       = (r_state != IDLE);
   assign bus.end_flag   = r_end;

endmodule

// File: tb/tb_s2c_responder.sv
// Randomized bench for s2c_responder against a packet-level reference model.
// Latency: n/a.
// Backpressure: drives random req gaps and rsp_ready patterns.
module tb_s2c_responder;
   localparam int          DS     = 16;
   localparam int          TMO    = 8;
   localparam logic [31:0] FN_END = 32'h0000_00FF;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   bit   exp_end;

   logic [31:0] pkt_data [DS];
   logic [31:0] usr_data [DS];
   logic [31:0] usr_ret;

   s2c_responder_if #(.DATA_SIZE(DS)) bus ();

   s2c_responder #(
      .DATA_SIZE   (DS),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.req_valid  = 1'b0;
      bus.req_data   = '0;
      bus.rsp_ready  = 1'b0;
      bus.call_ready = 1'b0;
      bus.done_valid = 1'b0;
      bus.done_ret   = '0;
      bus.done_data  = '0;
   endtask

   task automatic make_data(input bit pattern);
      for (int i = 0; i < DS; i++) begin
         pkt_data[i] = pattern ? 32'(i) : $urandom;
         usr_data[i] = pattern ? 32'(i + 100) : $urandom;
      end
      usr_ret = pattern ? 32'd7 : $urandom;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      exp_end = 1'b0;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_end_flag", bus.end_flag, 0);
      chk("rst_call_valid", bus.call_valid, 0);
      chk("rst_req_ready", bus.req_ready, 1);
   endtask

   // One packet end to end. rsp_mode: 0 always ready, 1 toggling, 2 random.
   task automatic run_pkt(input logic [31:0] id, input logic [31:0] fn, input int rsp_mode,
                          input bit gaps, input int call_dly, input bit junk_done, input bit no_done);
      logic [31:0] txq[$];
      logic [31:0] expq[$];
      logic [31:0] held;
      logic [31:0] w;
      bit          is_end;
      bit          chk_next;
      bit          stalled;
      bit          call_taken;
      bit          rdy;
      bit          ok;
      int          cyc;
      int          call_hi;
      int          done_dly;

      is_end = (fn == FN_END);
      chk_next = 0; stalled = 0; call_taken = 0; cyc = 0; call_hi = 0; done_dly = 0; held = '0;
      txq = {id, fn};
      for (int i = 0; i < DS; i++) txq.push_back(pkt_data[i]);
      // Reference: END echoes request data with ret 0; timeout returns all-ones and zeros; else user result.
      expq = {id, fn};
      if (is_end)       expq.push_back(32'h0);
      else if (no_done) expq.push_back(32'hFFFF_FFFF);
      else              expq.push_back(usr_ret);
      for (int i = 0; i < DS; i++)
         expq.push_back(is_end ? pkt_data[i] : (no_done ? 32'h0 : usr_data[i]));

      while (expq.size() > 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (chk_next) begin
            chk_next = 0;
            if (is_end) exp_end = 1'b1;
            chk("end_flag_after_rx", bus.end_flag, exp_end);
            chk("call_rise", bus.call_valid, !is_end);
         end

         bus.done_valid = 1'b0;
         if (bus.call_valid) begin
            call_hi++;
            ok = (bus.call_id == id) && (bus.call_fn == fn);
            for (int i = 0; i < DS; i++) if (bus.call_data[i*32 +: 32] != pkt_data[i]) ok = 0;
            chk("call_fields", ok, 1);
            bus.call_ready = (call_hi > call_dly);
            if (junk_done) begin
               bus.done_valid = 1'b1;
               bus.done_ret   = 32'hDEAD_BEEF;
               bus.done_data  = '1;
            end
            if (bus.call_ready) begin
               call_taken = 1;
               done_dly   = $urandom_range(0, 3);
            end
         end else begin
            bus.call_ready = 1'b0;
            if (call_taken && !no_done) begin
               if (done_dly == 0) begin
                  bus.done_valid = 1'b1;
                  bus.done_ret   = usr_ret;
                  for (int i = 0; i < DS; i++) bus.done_data[i*32 +: 32] = usr_data[i];
                  call_taken = 0;
               end else begin
                  done_dly--;
               end
            end
            if (no_done && bus.rsp_valid) begin
               bus.done_valid = 1'b1;
               bus.done_ret   = 32'h1234_5678;
               bus.done_data  = '1;
            end
         end

         if (txq.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            bus.req_valid = 1'b1;
            bus.req_data  = txq[0];
            if (bus.req_ready) begin
               void'(txq.pop_front());
               if (txq.size() == 0) chk_next = 1;
            end
         end else begin
            bus.req_valid = 1'b0;
            bus.req_data  = $urandom;
         end

         if (bus.rsp_valid) begin
            if (stalled) chk("rsp_hold", bus.rsp_data, held);
            chk("req_ready_in_tx", bus.req_ready, 0);
         end
         case (rsp_mode)
            0:       rdy = 1;
            1:       rdy = (cyc % 2) == 1;
            default: rdy = ($urandom_range(0, 1) == 1);
         endcase
         bus.rsp_ready = rdy;
         if (bus.rsp_valid && rdy) begin
            w = expq.pop_front();
            chk("rsp_word", bus.rsp_data, w);
            chk("rsp_last", bus.rsp_last, expq.size() == 0);
            stalled = 0;
         end else begin
            stalled = bus.rsp_valid;
            held    = bus.rsp_data;
         end
      end
      chk("rsp_remaining", expq.size(), 0);
      if (is_end) chk("end_no_call", call_hi, 0);

      @(negedge clk);
      idle_inputs();
      chk("post_busy", bus.busy, 0);
      chk("post_req_ready", bus.req_ready, 1);
      chk("post_rsp_valid", bus.rsp_valid, 0);
      chk("post_end_flag", bus.end_flag, exp_end);
   endtask

   // Drive a full normal packet, accept the call, then sit in WAIT for 'hold' cycles and reset.
   task automatic wait_then_reset(input int hold);
      logic [31:0] words[$];
      int          cyc;
      bit          took;
      cyc = 0; took = 0;
      words = {32'h77, 32'h3};
      for (int i = 0; i < DS; i++) words.push_back(pkt_data[i]);
      while (!took && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus.call_ready = bus.call_valid;
         if (bus.call_valid) took = 1;
         if (words.size() > 0) begin
            bus.req_valid = 1'b1;
            bus.req_data  = words[0];
            if (bus.req_ready) void'(words.pop_front());
         end else begin
            bus.req_valid = 1'b0;
         end
      end
      chk("wait_call_seen", took, 1);
      repeat (hold) begin
         @(negedge clk);
         bus.call_ready = 1'b0;
         bus.req_valid  = 1'b0;
         chk("wait_busy", bus.busy, 1);
         chk("wait_no_rsp", bus.rsp_valid, 0);
      end
      do_reset();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_end = 0;
      rst     = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("init_req_ready", bus.req_ready, 1);
      chk("init_busy", bus.busy, 0);
      chk("init_rsp_valid", bus.rsp_valid, 0);
      chk("init_end_flag", bus.end_flag, 0);
      chk("init_call_valid", bus.call_valid, 0);
      chk("init_call_id", bus.call_id, 0);

      // Directed single call
      make_data(1);
      run_pkt(32'd5, 32'd2, 0, 0, 0, 0, 0);

      // Backpressure: toggling and random rsp_ready with req gaps
      make_data(0);
      run_pkt($urandom, 32'd9, 1, 1, 0, 0, 0);
      make_data(0);
      run_pkt($urandom, 32'd17, 2, 1, 1, 0, 0);

      // End packet, then normal call, then repeated end
      for (int i = 0; i < DS; i++) pkt_data[i] = 32'hA5A5_A5A5;
      run_pkt(32'd11, FN_END, 0, 0, 0, 0, 0);
      make_data(0);
      run_pkt(32'd12, 32'd4, 0, 0, 0, 0, 0);
      make_data(0);
      run_pkt(32'd13, FN_END, 2, 1, 0, 0, 0);

      // Reset after 8 data words
      make_data(0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b1;
         bus.req_data  = (k == 0) ? 32'd21 : ((k == 1) ? 32'd1 : pkt_data[k-2]);
      end
      do_reset();
      make_data(0);
      run_pkt(32'd22, 32'd6, 0, 0, 0, 0, 0);

      // Reset during WAIT; without the watchdog WAIT also holds indefinitely
`ifdef S2C_RESP_TIMEOUT_EN
      wait_then_reset(TMO - 3);
`else
      wait_then_reset(40);
`endif
      make_data(0);
      run_pkt(32'd23, 32'd8, 1, 0, 0, 0, 0);

      // Call stall with junk done during CALL
      make_data(0);
      run_pkt(32'd24, 32'd10, 0, 0, 10, 1, 0);

`ifdef S2C_RESP_TIMEOUT_EN
      make_data(0);
      run_pkt(32'd25, 32'd12, 2, 0, 0, 0, 1);
      make_data(0);
      run_pkt(32'd26, 32'd13, 0, 0, 0, 0, 0);
`endif

      // Random mix
      for (int n = 0; n < 6; n++) begin
         make_data(0);
         run_pkt($urandom, ($urandom_range(0, 3) == 0) ? FN_END : 32'($urandom_range(0, 200)),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
